// File: rtl/sw_conditioner_pkg.sv
// Shared elevator constants for the switch/button conditioning front end.
// The default debounce window is derived from the board clock so that a
// clock change only needs to be made here.
package sw_conditioner_pkg;

    localparam int CLK_FREQ_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS      = 10;
    localparam int SW_N_DEFAULT     = 4;
    localparam int DB_COUNT_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Width of a counter that must be able to hold the value db_count.
    function automatic int cnt_width(input int db_count);
        if (db_count < 1) begin
            return 1;
        end else begin
            return $clog2(db_count + 1);
        end
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced channel: two-flop synchronizer, hold-time counter, accepted
// level and a registered rising-edge pulse aligned with the accepted level.
module sw_debounce_bit
    import sw_conditioner_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_stable,
    output logic sw_rise
);

    localparam int              CW       = cnt_width(DB_COUNT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_COUNT - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          rise_r;
    logic [CW-1:0] cnt_r;
    logic          mismatch_s;
    logic          expire_s;

    // The synchronized level disagrees with the accepted one, and the disagreement
    // has now lasted the full window.
    assign mismatch_s = (sync2_r != stable_r);
    assign expire_s   = mismatch_s && (cnt_r == CNT_LAST);

    // Bring the asynchronous board level into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sw_in;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level once the window expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
        end else if (!mismatch_s) begin
            cnt_r    <= {CW{1'b0}};
            rise_r   <= 1'b0;
        end else if (expire_s) begin
            cnt_r    <= {CW{1'b0}};
            stable_r <= sync2_r;
            rise_r   <= sync2_r;
        end else begin
            cnt_r    <= cnt_r + CW'(1);
            rise_r   <= 1'b0;
        end
    end

    assign sw_stable = stable_r;
    assign sw_rise   = rise_r;

endmodule

// File: rtl/sw_conditioner.sv
// Elevator call-button conditioner: N independent debounced channels plus a
// sticky per-floor request latch cleared by the controller once served.
module sw_conditioner
    import sw_conditioner_pkg::*;
#(
    parameter int N        = SW_N_DEFAULT,
    parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_in,
    input  logic [N-1:0] req_clr,
    output logic [N-1:0] sw_stable,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] req,
    output logic         req_any
);

    logic [N-1:0] req_r;

    for (genvar i = 0; i < N; i++) begin : g_ch
        sw_debounce_bit #(
            .DB_COUNT (DB_COUNT)
        ) u_db (
            .clk       (clk),
            .rst       (rst),
            .sw_in     (sw_in[i]),
            .sw_stable (sw_stable[i]),
            .sw_rise   (sw_rise[i])
        );
    end

    // Sticky call latch; a new press in the same cycle as a clear wins so no call is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r <= {N{1'b0}};
        end else begin
            req_r <= (req_r & ~req_clr) | sw_rise;
        end
    end

    assign req     = req_r;
    assign req_any = |req_r;

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner (N=4, DB_COUNT=4). A window-based
// reference model predicts every output each cycle; directed steps add
// explicit expectations for the key scenarios.
module tb_sw_conditioner;

    localparam int N  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw_in;
    logic [N-1:0] req_clr;
    logic [N-1:0] sw_stable;
    logic [N-1:0] sw_rise;
    logic [N-1:0] req;
    logic         req_any;

    int checks = 0;
    int errors = 0;
    int rise_seen [N];

    // Reference model: hist[k] is the sw_in value sampled k+1 edges ago.
    logic [N-1:0] hist [DB+1];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_req;

    sw_conditioner #(.N(N), .DB_COUNT(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .req_clr   (req_clr),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .req       (req),
        .req_any   (req_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= DB; k++) hist[k] = '0;
        m_stable = '0;
        m_rise   = '0;
        m_req    = '0;
    endtask

    // A level is accepted when the synchronized input (samples 2..DB+1 edges
    // old) disagreed with the accepted level for DB consecutive edges.
    task automatic model_edge();
        logic [N-1:0] nstable;
        logic [N-1:0] nrise;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                bit acc;
                acc = 1'b1;
                for (int k = 1; k <= DB; k++) begin
                    if (hist[k][i] == m_stable[i]) acc = 1'b0;
                end
                nstable[i] = acc ? ~m_stable[i] : m_stable[i];
                nrise[i]   = acc & ~m_stable[i];
            end
            m_req    = (m_req & ~req_clr) | m_rise;
            m_stable = nstable;
            m_rise   = nrise;
            for (int k = DB; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = sw_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_stable", sw_stable, m_stable);
        chk("model_rise", sw_rise, m_rise);
        chk("model_req", req, m_req);
        chk("model_req_any", {3'b000, req_any}, {3'b000, |m_req});
        for (int i = 0; i < N; i++) begin
            if (sw_rise[i] === 1'b1) rise_seen[i]++;
        end
    endtask

    task automatic clear_rise_seen();
        for (int i = 0; i < N; i++) rise_seen[i] = 0;
    endtask

    initial begin
        clear_rise_seen();
        // Reset with all switches held high
        rst = 1'b1; sw_in = 4'hF; req_clr = 4'h0;
        model_reset();
        #1;
        chk("rst_stable", sw_stable, 4'h0);
        chk("rst_req_any", {3'b000, req_any}, 4'h0);
        repeat (3) tick();
        chk("rst_rise", sw_rise, 4'h0);
        chk("rst_req", req, 4'h0);

        // Held switches accepted as fresh presses after release
        @(negedge clk); rst = 1'b0;
        repeat (5) tick();
        chk("por_stable_early", sw_stable, 4'h0);
        tick();
        chk("por_stable", sw_stable, 4'hF);
        chk("por_rise", sw_rise, 4'hF);
        tick();
        chk("por_rise_one_cycle", sw_rise, 4'h0);
        chk("por_req", req, 4'hF);
        chk("por_req_any", {3'b000, req_any}, 4'h1);

        // Serve all floors and release all switches
        req_clr = 4'hF; tick(); req_clr = 4'h0;
        chk("clr_all_req", req, 4'h0);
        sw_in = 4'h0;
        repeat (8) tick();
        chk("fall_all_stable", sw_stable, 4'h0);

        // Glitch shorter than the window on channel 0
        clear_rise_seen();
        sw_in = 4'b0001; repeat (3) tick();
        sw_in = 4'b0000; repeat (10) tick();
        chk("glitch_stable", sw_stable, 4'h0);
        chk("glitch_req", req, 4'h0);
        chk("glitch_rise_count", 4'(rise_seen[0]), 4'h0);

        // Bouncing contact on channel 1, then a solid press
        clear_rise_seen();
        sw_in = 4'b0010; tick();
        sw_in = 4'b0000; tick();
        sw_in = 4'b0010; tick();
        sw_in = 4'b0000; tick();
        sw_in = 4'b0010;
        repeat (5) tick();
        chk("bounce_rise_early", sw_rise, 4'h0);
        tick();
        chk("bounce_rise", sw_rise, 4'b0010);
        tick();
        chk("bounce_req", req, 4'b0010);
        chk("bounce_req_any", {3'b000, req_any}, 4'h1);
        repeat (4) tick();
        chk("bounce_rise_count", 4'(rise_seen[1]), 4'h1);

        // Floor 1 served
        req_clr = 4'b0010; tick(); req_clr = 4'h0;
        chk("clear_req", req, 4'h0);
        chk("clear_req_any", {3'b000, req_any}, 4'h0);
        chk("clear_stable_kept", sw_stable, 4'b0010);

        // Clear arrives in the same cycle the press is latched
        sw_in = 4'b0110;
        repeat (6) tick();
        chk("collision_rise", sw_rise, 4'b0100);
        req_clr = 4'b0100; tick(); req_clr = 4'h0;
        chk("collision_req", req, 4'b0100);

        // Release after acceptance on channel 3
        sw_in = 4'b1110;
        repeat (7) tick();
        chk("release_setup_req", req, 4'b1100);
        clear_rise_seen();
        sw_in = 4'b0110;
        repeat (5) tick();
        chk("release_stable_early", sw_stable, 4'b1110);
        tick();
        chk("release_stable", sw_stable, 4'b0110);
        chk("release_rise", sw_rise, 4'h0);
        chk("release_req", req, 4'b1100);
        chk("release_rise_count", 4'(rise_seen[3]), 4'h0);

        // Reset mid-debounce discards the partial count
        sw_in = 4'b0111;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1 model_reset();
        chk("async_rst_stable", sw_stable, 4'h0);
        chk("async_rst_req", req, 4'h0);
        chk("async_rst_req_any", {3'b000, req_any}, 4'h0);
        repeat (2) tick();
        @(negedge clk); rst = 1'b0;
        repeat (5) tick();
        chk("mid_rst_stable_early", sw_stable, 4'h0);
        tick();
        chk("mid_rst_stable", sw_stable, 4'b0111);
        chk("mid_rst_rise", sw_rise, 4'b0111);
        tick();
        chk("mid_rst_req", req, 4'b0111);

        // Random activity on all channels against the model
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) sw_in[i] = ~sw_in[i];
            end
            req_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
